// File: rtl/motoro3_pkg.sv
// Shared types and constants for the motoro3 step sequencer and its step timer.
// Includes the FSM state encoding, step limits and the helpers used by the top level.
package motoro3_pkg;

    localparam int CNT_W  = 25;
    localparam int STEP_W = 4;
    localparam int CYC_W  = 16;

    localparam logic [STEP_W-1:0] STEP_MAX     = 4'd11;
    localparam logic [CNT_W-1:0]  STEP_LEN_MIN = 25'd4;
    localparam logic [STEP_W-1:0] HALF_END_A   = 4'd5;
    localparam logic [STEP_W-1:0] HALF_END_B   = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } m3_state_e;

    // Steps shorter than four clocks would make the position strobes collide.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] len);
        return (len < STEP_LEN_MIN) ? STEP_LEN_MIN : len;
    endfunction

    function automatic logic [STEP_W-1:0] first_step(input logic rev);
        return rev ? STEP_MAX : '0;
    endfunction

    function automatic logic [STEP_W-1:0] next_step(input logic [STEP_W-1:0] step,
                                                    input logic rev);
        if (rev) return (step == '0) ? STEP_MAX : step - 4'd1;
        return (step == STEP_MAX) ? '0 : step + 4'd1;
    endfunction

endpackage

// File: rtl/motoro3_step_sequencer_if.sv
// Control and status bundle of the step sequencer.
// The dirRev input exists only when M3_STEP_DIR_EN is defined.
interface motoro3_step_sequencer_if;
    import motoro3_pkg::*;

    logic              start;
    logic              stop;
    logic              abort;
    logic [CNT_W-1:0]  m3r_stepLen;
`ifdef M3_STEP_DIR_EN
    logic              dirRev;
`endif
    logic [STEP_W-1:0] sgStep;
    logic [CNT_W-1:0]  m3cnt;
    logic              m3cntFirst2;
    logic              m3cntFirst1;
    logic              m3cntLast2;
    logic              m3cntLast1;
    logic              pwmActive1;
    logic              pwmLastStep1;
    logic [CYC_W-1:0]  cycleCnt;
    logic              busy;

    modport master (
        output start, stop, abort, m3r_stepLen,
`ifdef M3_STEP_DIR_EN
        output dirRev,
`endif
        input  sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1,
        input  pwmActive1, pwmLastStep1, cycleCnt, busy
    );

    modport slave (
        input  start, stop, abort, m3r_stepLen,
`ifdef M3_STEP_DIR_EN
        input  dirRev,
`endif
        output sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1,
        output pwmActive1, pwmLastStep1, cycleCnt, busy
    );

endinterface

// File: rtl/motoro3_step_timer.sv
// Per-step down-counter with position strobes; load captures the step length.
// Counts on the falling clock edge alongside the PWM generator.
module motoro3_step_timer
    import motoro3_pkg::*;
(
    input  logic             clk,
    input  logic             nRst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_len,
    output logic [CNT_W-1:0] o_count,
    output logic             o_first2,
    output logic             o_first1,
    output logic             o_last2,
    output logic             o_last1
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_len;
    logic             r_run;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(negedge clk) begin
        if (nRst || i_clr) begin
            r_count <= '0;
            r_len   <= STEP_LEN_MIN;
            r_run   <= 1'b0;
        end else if (i_load) begin
            r_count <= i_len - 25'd1;
            r_len   <= i_len;
            r_run   <= 1'b1;
        end else if (r_run && (r_count != '0)) begin
            r_count <= r_count - 25'd1;
        end
    end

    assign o_count  = r_count;
    assign o_first2 = r_run && (r_count == r_len - 25'd1);
    assign o_first1 = r_run && (r_count == r_len - 25'd2);
    assign o_last2  = r_run && (r_count == 25'd1);
    assign o_last1  = r_run && (r_count == '0);

endmodule

// File: rtl/motoro3_step_sequencer.sv
// 12-step commutation sequencer: IDLE/RUN/STOPPING control, step and cycle counting.
// Optional reverse stepping is enabled with the M3_STEP_DIR_EN macro.
module motoro3_step_sequencer
    import motoro3_pkg::*;
(
    input logic                     clk,
    input logic                     nRst,
    motoro3_step_sequencer_if.slave bus
);

    m3_state_e         r_state;
    m3_state_e         w_state_nxt;
    logic [STEP_W-1:0] r_step;
    logic [CYC_W-1:0]  r_cycle;
    logic              w_load;
    logic              w_clr;
    logic              w_dir_in;
    logic [STEP_W-1:0] w_end_step;
    logic [CNT_W-1:0]  w_count;
    logic              w_first2, w_first1, w_last2, w_last1;
    logic              w_busy;

`ifdef M3_STEP_DIR_EN
    logic r_dir;

    always_ff @(negedge clk) begin
        if (nRst)        r_dir <= 1'b0;
        else if (w_load) r_dir <= bus.dirRev;
    end

    assign w_dir_in   = bus.dirRev;
    assign w_end_step = r_dir ? '0 : STEP_MAX;
`else
    assign w_dir_in   = 1'b0;
    assign w_end_step = STEP_MAX;
`endif

    motoro3_step_timer u_timer (
        .clk      (clk),
        .nRst     (nRst),
        .i_clr    (w_clr),
        .i_load   (w_load),
        .i_len    (eff_len(bus.m3r_stepLen)),
        .o_count  (w_count),
        .o_first2 (w_first2),
        .o_first1 (w_first1),
        .o_last2  (w_last2),
        .o_last1  (w_last1)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_clr       = 1'b0;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_RUN;
                        w_load      = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) w_state_nxt = ST_STOPPING;
                    if (w_last1)  w_load      = 1'b1;
                end
                ST_STOPPING: begin
                    if (w_last1) begin
                        if (r_step == w_end_step) begin
                            w_state_nxt = ST_IDLE;
                            w_clr       = 1'b1;
                        end else begin
                            w_load = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_clr       = 1'b1;
                end
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (nRst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_cycle <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clr)       r_step <= '0;
            else if (w_load) r_step <= (r_state == ST_IDLE) ? first_step(w_dir_in)
                                                            : next_step(r_step, w_dir_in);
            // Abort returns every output, the cycle count included, to its reset value.
            if (bus.abort)                                r_cycle <= '0;
            else if (w_last1 && (r_step == w_end_step))   r_cycle <= r_cycle + 16'd1;
        end
    end

    assign w_busy           = (r_state != ST_IDLE);
    assign bus.busy         = w_busy;
    assign bus.pwmActive1   = w_busy;
    assign bus.pwmLastStep1 = w_busy && ((r_step == HALF_END_A) || (r_step == HALF_END_B));
    assign bus.sgStep       = r_step;
    assign bus.cycleCnt     = r_cycle;
    assign bus.m3cnt        = w_count;
    assign bus.m3cntFirst2  = w_first2;
    assign bus.m3cntFirst1  = w_first1;
    assign bus.m3cntLast2   = w_last2;
    assign bus.m3cntLast1   = w_last1;

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Scoreboard bench for motoro3_step_sequencer: the driver pushes model predictions,
// the monitor compares them against the DUT every rising edge (DUT updates on falling).
module tb_motoro3_step_sequencer;

    typedef struct packed {
        logic [3:0]  step;
        logic [24:0] cnt;
        logic        f2, f1, l2, l1;
        logic        act, last, busy;
        logic [15:0] cyc;
    } obs_t;

    logic clk = 1'b0;
    logic nRst;

    motoro3_step_sequencer_if bus ();

    motoro3_step_sequencer dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #50 clk = ~clk;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_obs   = 0;

    // Reference model: position counted upward from the start of the step.
    bit          m_active   = 1'b0;
    bit          m_stopping = 1'b0;
    int          m_step     = 0;
    int          m_pos      = 0;
    int          m_len      = 4;
    logic [15:0] m_cycles   = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_step(input bit st, input bit sp, input bit ab, input int len,
                              input bit rs);
        int eff;
        bit eos;
        eff = (len < 4) ? 4 : len;
        if (rs || ab) begin
            m_active = 0; m_stopping = 0; m_step = 0; m_pos = 0; m_cycles = '0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_stopping = 0; m_step = 0; m_pos = 0; m_len = eff;
            end
        end else begin
            eos = (m_pos == m_len - 1);
            if (eos && m_step == 11) m_cycles = m_cycles + 16'd1;
            if (eos && m_step == 11 && m_stopping) begin
                m_active = 0; m_stopping = 0; m_step = 0; m_pos = 0;
            end else if (eos) begin
                m_step = (m_step + 1) % 12; m_pos = 0; m_len = eff;
            end else begin
                m_pos++;
            end
            if (sp && m_active) m_stopping = 1;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o      = '0;
        o.cyc  = m_cycles;
        if (m_active) begin
            o.step = 4'(m_step);
            o.cnt  = 25'(m_len - 1 - m_pos);
            o.f2   = (m_pos == 0);
            o.f1   = (m_pos == 1);
            o.l2   = (m_pos == m_len - 2);
            o.l1   = (m_pos == m_len - 1);
            o.act  = 1'b1;
            o.last = (m_step == 5) || (m_step == 11);
            o.busy = 1'b1;
        end
        return o;
    endfunction

    task automatic cyc(input bit st, input bit sp, input bit ab, input int len, input bit rs);
        @(posedge clk);
        #1;
        bus.start       = st;
        bus.stop        = sp;
        bus.abort       = ab;
        bus.m3r_stepLen = 25'(len);
        nRst            = rs;
        model_step(st, sp, ab, len, rs);
        exp_q.push_back(model_obs());
    endtask

    task automatic run(input int n, input int len);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, len, 0);
    endtask

    // Monitor: every rising edge the DUT presents a settled state to compare.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {bus.sgStep, bus.m3cnt, bus.m3cntFirst2, bus.m3cntFirst1,
                     bus.m3cntLast2, bus.m3cntLast1, bus.pwmActive1, bus.pwmLastStep1,
                     bus.busy, bus.cycleCnt};
                check($sformatf("obs@%0d", n_obs), 64'(g), 64'(e));
                check($sformatf("strobe_overlap@%0d", n_obs),
                      64'($countones({g.f2, g.f1, g.l2, g.l1}) > 1), 64'd0);
                n_obs++;
            end
        end
    end

    initial begin
        bus.start = 0; bus.stop = 0; bus.abort = 0; bus.m3r_stepLen = '0;
`ifdef M3_STEP_DIR_EN
        bus.dirRev = 1'b0;
`endif
        nRst = 1'b1;

        // Reset and idle hold
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 10, 1);
        run(3, 10);

        // Length 10: full 12-step cycle, cycleCnt reaches 1 after 120 clocks
        cyc(1, 0, 0, 10, 0);
        run(125, 10);
        cyc(0, 0, 1, 10, 0);

        // Stop during step 3: finish the cycle, then idle
        cyc(1, 0, 0, 10, 0);
        run(33, 10);
        cyc(0, 1, 0, 10, 0);
        run(100, 10);

        // Abort, start and stop together during step 7
        cyc(1, 0, 0, 10, 0);
        run(75, 10);
        cyc(1, 1, 1, 10, 0);
        run(3, 10);

        // Step length change mid step 2
        cyc(1, 0, 0, 10, 0);
        run(23, 10);
        run(40, 20);
        cyc(0, 0, 1, 20, 0);

        // Length below minimum clamps to 4
        cyc(1, 0, 0, 2, 0);
        run(20, 2);
        cyc(0, 0, 1, 2, 0);

        // Reset pulse mid step 6
        cyc(1, 0, 0, 10, 0);
        run(65, 10);
        cyc(0, 0, 0, 10, 1);
        run(3, 10);

        // Randomized requests with a length that changes every clock
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 255) < 40, $urandom_range(0, 99) < 3,
                $urandom_range(0, 199) < 2, int'($urandom_range(0, 9)),
                $urandom_range(0, 299) == 0);
        end

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
